block_put: RTL and testbench

Write-back counterpart of the block extractor. It takes a JxK result block (row-major) and stores it into a flattened row-major matrix buffer at (start_row, start_col), one element per cycle through a single-port memory interface. An optional accumulate mode does read-modify-write, adding each block element to the value already stored. It sits after the systolic/compute core and writes partial or final results back to the result matrix buffer.

---
 rtl/block_put_if.sv | 33 +++
 rtl/block_put.sv | 128 ++++++++++++
 tb/tb_block_put.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/block_put_if.sv
// Bus bundle for block_put: request/config inputs, single-port buffer access and status.
// slave is the block_put side; master is the environment that drives requests and memory.
interface block_put_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned J      = 2,
  parameter int unsigned K      = 2,
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DIM_W  = 10
);
  logic                    start;
  logic [DIM_W-1:0]        start_row;
  logic [DIM_W-1:0]        start_col;
  logic [DIM_W-1:0]        num_cols;
  logic [DIM_W-1:0]        matrix_len;
  logic                    accumulate;
  logic [DATA_W*J*K-1:0]   block;
  logic [ADDR_W-1:0]       mem_addr;
  logic                    mem_we;
  logic [DATA_W-1:0]       mem_wdata;
  logic [DATA_W-1:0]       mem_rdata;
  logic                    busy;
  logic                    block_put_done;

  modport master (
    output start, start_row, start_col, num_cols, matrix_len, accumulate, block, mem_rdata,
    input  mem_addr, mem_we, mem_wdata, busy, block_put_done
  );

  modport slave (
    input  start, start_row, start_col, num_cols, matrix_len, accumulate, block, mem_rdata,
    output mem_addr, mem_we, mem_wdata, busy, block_put_done
  );
endinterface

// File: rtl/block_put.sv
// Writes a JxK row-major block into a row-major matrix buffer, one element per cycle,
// clipping at the matrix edge; optional read-add-write accumulate mode.
module block_put #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned J      = 2,
  parameter int unsigned K      = 2,
  parameter int unsigned ADDR_W = 10
) (
  input logic         clk,
  input logic         rst,
  block_put_if.slave  bus
);

  localparam int unsigned DIM_W = 10;
  localparam int unsigned IW    = (J > 1) ? $clog2(J) : 1;
  localparam int unsigned KW    = (K > 1) ? $clog2(K) : 1;
  localparam int unsigned CW    = 24;

  typedef enum logic [1:0] {StIdle, StRead, StWrite, StDone} state_e;

  state_e                r_state, w_state_nxt;
  logic [DIM_W-1:0]      r_row0, r_col0, r_ncols, r_nrows;
  logic                  r_acc;
  logic [DATA_W*J*K-1:0] r_block;
  logic [IW-1:0]         r_i, w_i_nxt;
  logic [KW-1:0]         r_j, w_j_nxt;
  logic [ADDR_W-1:0]     r_addr;
  logic [DATA_W-1:0]     r_wdata;

  logic                  w_busy;
  logic                  w_last;
  logic                  w_inb;
  logic [31:0]           w_e;
  logic [CW-1:0]         w_row, w_col;
  logic [ADDR_W-1:0]     w_addr;
  logic [DATA_W-1:0]     w_elem;
  logic [DATA_W-1:0]     w_wdata;

  assign w_busy = (r_state == StRead) || (r_state == StWrite);
  assign w_last = (r_i == IW'(J - 1)) && (r_j == KW'(K - 1));
  assign w_e    = 32'(r_i) * K + 32'(r_j);
  assign w_row  = CW'(r_row0) + CW'(r_i);
  assign w_col  = CW'(r_col0) + CW'(r_j);
  // r_nrows is zero when num_cols is zero, so the row test alone already clips everything
  assign w_inb  = (r_ncols != '0) && (w_row < CW'(r_nrows)) && (w_col < CW'(r_ncols));
  assign w_addr = ADDR_W'(w_row * CW'(r_ncols) + w_col);

  always_comb begin
    w_elem = '0;
    for (int unsigned e = 0; e < J * K; e++) begin
      if (w_e == e) w_elem = r_block[e*DATA_W +: DATA_W];
    end
  end

  // Sum wraps at DATA_W; mem_rdata is the value read in the preceding READ cycle
  assign w_wdata = r_acc ? (bus.mem_rdata + w_elem) : w_elem;

  always_comb begin
    w_state_nxt = r_state;
    w_i_nxt     = r_i;
    w_j_nxt     = r_j;
    case (r_state)
      StIdle: begin
        if (bus.start) begin
          w_state_nxt = bus.accumulate ? StRead : StWrite;
          w_i_nxt     = '0;
          w_j_nxt     = '0;
        end
      end
      StRead: w_state_nxt = StWrite;
      StWrite: begin
        if (w_last) begin
          w_state_nxt = StDone;
          w_i_nxt     = '0;
          w_j_nxt     = '0;
        end else begin
          w_state_nxt = r_acc ? StRead : StWrite;
          if (r_j == KW'(K - 1)) begin
            w_j_nxt = '0;
            w_i_nxt = r_i + IW'(1);
          end else begin
            w_j_nxt = r_j + KW'(1);
          end
        end
      end
      StDone:  w_state_nxt = StIdle;
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StIdle;
      r_i     <= '0;
      r_j     <= '0;
      r_row0  <= '0;
      r_col0  <= '0;
      r_ncols <= '0;
      r_nrows <= '0;
      r_acc   <= 1'b0;
      r_block <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_i     <= w_i_nxt;
      r_j     <= w_j_nxt;
      if ((r_state == StIdle) && bus.start) begin
        r_row0  <= bus.start_row;
        r_col0  <= bus.start_col;
        r_ncols <= bus.num_cols;
        r_nrows <= (bus.num_cols != '0) ? (bus.matrix_len / bus.num_cols) : '0;
        r_acc   <= bus.accumulate;
        r_block <= bus.block;
      end
      if (w_busy) r_addr <= w_addr;
      if (r_state == StWrite) r_wdata <= w_wdata;
    end
  end

  // Address/data registers keep the last driven values visible while idle
  assign bus.mem_addr       = w_busy ? w_addr : r_addr;
  assign bus.mem_we         = (r_state == StWrite) && w_inb;
  assign bus.mem_wdata      = (r_state == StWrite) ? w_wdata : r_wdata;
  assign bus.busy           = w_busy;
  assign bus.block_put_done = (r_state == StDone);

endmodule

// File: tb/tb_block_put.sv
// Randomized and directed bench for block_put with a behavioural buffer model.
module tb_block_put;
  localparam int unsigned DW = 16;
  localparam int unsigned J  = 2;
  localparam int unsigned K  = 2;
  localparam int unsigned AW = 10;
  localparam int unsigned NE = J * K;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  block_put_if #(.DATA_W(DW), .J(J), .K(K), .ADDR_W(AW)) bus ();

  block_put #(.DATA_W(DW), .J(J), .K(K), .ADDR_W(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [DW-1:0] mem     [1024];
  logic [DW-1:0] ref_mem [1024];
  logic [DW-1:0] rdata_q;
  logic          pl_we   = 1'b0;
  logic [AW-1:0] pl_addr = '0;
  logic [DW-1:0] pl_data = '0;

  assign bus.mem_rdata = rdata_q;

  always @(posedge clk) begin
    if (pl_we) mem[pl_addr] <= pl_data;
    else if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
    rdata_q <= mem[bus.mem_addr];
  end

  int checks = 0;
  int errors = 0;

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
    pl_we   = 1'b1;
    pl_addr = a;
    pl_data = d;
    @(posedge clk); #1;
    pl_we      = 1'b0;
    ref_mem[a] = d;
  endtask

  task automatic drive_random_inputs();
    bus.start_row  = 10'($urandom);
    bus.start_col  = 10'($urandom);
    bus.num_cols   = 10'($urandom);
    bus.matrix_len = 10'($urandom);
    bus.accumulate = 1'($urandom);
    bus.block      = {$urandom, $urandom};
  endtask

  // Drives one request and checks every cycle against the element-by-element model.
  task automatic run_op(input logic [9:0] srow, input logic [9:0] scol, input logic [9:0] ncols,
                        input logic [9:0] mlen, input bit acc, input logic [NE*DW-1:0] blk,
                        input int rst_at, input bit restart, input bit start_in_done);
    int            nrows, row, col, af, n;
    bit            inb, seen_done;
    logic [AW-1:0] a;
    logic [DW-1:0] el, expw;
    nrows = (ncols == 0) ? 0 : int'(mlen) / int'(ncols);
    bus.start      = 1'b1;
    bus.start_row  = srow;
    bus.start_col  = scol;
    bus.num_cols   = ncols;
    bus.matrix_len = mlen;
    bus.accumulate = acc;
    bus.block      = blk;
    @(posedge clk); #1;
    bus.start = 1'b0;
    drive_random_inputs();
    n = 1;
    for (int e = 0; e < int'(NE); e++) begin
      row  = int'(srow) + e / int'(K);
      col  = int'(scol) + e % int'(K);
      inb  = (ncols != 0) && (row < nrows) && (col < int'(ncols));
      af   = row * int'(ncols) + col;
      a    = af[AW-1:0];
      el   = blk[e*DW +: DW];
      for (int ph = (acc ? 0 : 1); ph < 2; ph++) begin
        if (n > 1) begin @(posedge clk); #1; end
        if (restart && n == 2) begin drive_random_inputs(); bus.start = 1'b1; end
        if (restart && n == 3) bus.start = 1'b0;
        expw = acc ? (ref_mem[a] + el) : el;
        checks++;
        if (bus.busy !== 1'b1) begin
          errors++; $display("FAIL busy c%0d: got %b want 1", n, bus.busy);
        end
        checks++;
        if (bus.block_put_done !== 1'b0) begin
          errors++; $display("FAIL done_early c%0d: got %b want 0", n, bus.block_put_done);
        end
        checks++;
        if (bus.mem_we !== (ph == 1 && inb)) begin
          errors++; $display("FAIL we c%0d: got %b want %b", n, bus.mem_we, (ph == 1 && inb));
        end
        checks++;
        if (bus.mem_addr !== a) begin
          errors++; $display("FAIL addr c%0d: got %0d want %0d", n, bus.mem_addr, a);
        end
        if (ph == 1 && inb) begin
          checks++;
          if (bus.mem_wdata !== expw) begin
            errors++; $display("FAIL wdata c%0d: got %h want %h", n, bus.mem_wdata, expw);
          end
          ref_mem[a] = expw;
        end
        if (rst_at == n) begin
          rst = 1'b1;
          @(posedge clk); #1;
          rst = 1'b0;
          checks++;
          if (bus.mem_we !== 1'b0 || bus.busy !== 1'b0 || bus.block_put_done !== 1'b0 ||
              bus.mem_addr !== '0) begin
            errors++;
            $display("FAIL abort: got we=%b busy=%b done=%b addr=%0d want 0 0 0 0",
                     bus.mem_we, bus.busy, bus.block_put_done, bus.mem_addr);
          end
          seen_done = 1'b0;
          for (int c = 0; c < int'(2 * NE + 2); c++) begin
            if (bus.block_put_done === 1'b1 || bus.mem_we === 1'b1) seen_done = 1'b1;
            @(posedge clk); #1;
          end
          checks++;
          if (seen_done) begin
            errors++; $display("FAIL abort_quiet: got activity 1 want 0");
          end
          return;
        end
        n++;
      end
    end
    @(posedge clk); #1;
    checks++;
    if (bus.block_put_done !== 1'b1 || bus.busy !== 1'b0 || bus.mem_we !== 1'b0) begin
      errors++;
      $display("FAIL done_cycle c%0d: got done=%b busy=%b we=%b want 1 0 0",
               n, bus.block_put_done, bus.busy, bus.mem_we);
    end
    if (start_in_done) begin drive_random_inputs(); bus.start = 1'b1; end
    @(posedge clk); #1;
    bus.start = 1'b0;
    checks++;
    if (bus.block_put_done !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL after_done: got done=%b busy=%b want 0 0", bus.block_put_done, bus.busy);
    end
    if (start_in_done) begin
      @(posedge clk); #1;
      checks++;
      if (bus.busy !== 1'b0) begin
        errors++; $display("FAIL start_in_done: got busy=%b want 0", bus.busy);
      end
    end
    for (int e = 0; e < int'(NE); e++) begin
      row = int'(srow) + e / int'(K);
      col = int'(scol) + e % int'(K);
      af  = row * int'(ncols) + col;
      a   = af[AW-1:0];
      checks++;
      if (mem[a] !== ref_mem[a]) begin
        errors++; $display("FAIL mem[%0d]: got %h want %h", a, mem[a], ref_mem[a]);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.start = 1'b0;
    drive_random_inputs();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus.mem_addr !== '0 || bus.mem_we !== 1'b0 || bus.mem_wdata !== '0 ||
        bus.busy !== 1'b0 || bus.block_put_done !== 1'b0) begin
      errors++;
      $display("FAIL reset: got addr=%0d we=%b wdata=%h busy=%b done=%b want all 0",
               bus.mem_addr, bus.mem_we, bus.mem_wdata, bus.busy, bus.block_put_done);
    end
    rst = 1'b0;
    for (int a = 0; a < 1024; a++) preload(AW'(a), DW'($urandom));
  endtask

  task automatic test_overwrite();
    run_op(10'd1, 10'd1, 10'd4, 10'd16, 1'b0, {16'hDDDD, 16'hCCCC, 16'hBBBB, 16'hAAAA}, 0, 0, 0);
    checks++;
    if (mem[5] !== 16'hAAAA || mem[6] !== 16'hBBBB || mem[9] !== 16'hCCCC ||
        mem[10] !== 16'hDDDD) begin
      errors++;
      $display("FAIL overwrite_fixed: got %h %h %h %h want aaaa bbbb cccc dddd",
               mem[5], mem[6], mem[9], mem[10]);
    end
  endtask

  task automatic test_clip();
    logic [DW-1:0] before16;
    before16 = mem[16];
    run_op(10'd3, 10'd3, 10'd4, 10'd16, 1'b0, {16'h4444, 16'h3333, 16'h2222, 16'h1111}, 0, 0, 0);
    checks++;
    if (mem[15] !== 16'h1111 || mem[16] !== before16) begin
      errors++;
      $display("FAIL clip_fixed: got %h %h want 1111 %h", mem[15], mem[16], before16);
    end
  endtask

  task automatic test_accumulate();
    preload(10'd5, 16'd10);
    preload(10'd6, 16'd10);
    preload(10'd9, 16'd10);
    preload(10'd10, 16'd10);
    run_op(10'd1, 10'd1, 10'd4, 10'd16, 1'b1, {16'd4, 16'd3, 16'd2, 16'd1}, 0, 0, 0);
    checks++;
    if (mem[5] !== 16'd11 || mem[6] !== 16'd12 || mem[9] !== 16'd13 || mem[10] !== 16'd14) begin
      errors++;
      $display("FAIL accum_fixed: got %0d %0d %0d %0d want 11 12 13 14",
               mem[5], mem[6], mem[9], mem[10]);
    end
  endtask

  task automatic test_wrap();
    preload(10'd0, 16'hFFFF);
    run_op(10'd0, 10'd0, 10'd4, 10'd16, 1'b1, {16'h0, 16'h0, 16'h0, 16'h0002}, 0, 0, 0);
    checks++;
    if (mem[0] !== 16'h0001) begin
      errors++; $display("FAIL wrap: got %h want 0001", mem[0]);
    end
  endtask

  task automatic test_control();
    run_op(10'd1, 10'd1, 10'd4, 10'd16, 1'b0, {$urandom, $urandom}, 0, 1, 1);
    run_op(10'd1, 10'd1, 10'd4, 10'd16, 1'b0, {$urandom, $urandom}, 2, 0, 0);
    run_op(10'd1, 10'd1, 10'd4, 10'd16, 1'b1, {$urandom, $urandom}, 3, 0, 0);
    run_op(10'd0, 10'd2, 10'd4, 10'd16, 1'b1, {$urandom, $urandom}, 0, 1, 0);
  endtask

  task automatic test_zero_cols();
    run_op(10'd1, 10'd1, 10'd0, 10'd16, 1'b0, {$urandom, $urandom}, 0, 0, 0);
    run_op(10'd0, 10'd0, 10'd0, 10'd16, 1'b1, {$urandom, $urandom}, 0, 0, 0);
  endtask

  task automatic test_random();
    for (int t = 0; t < 40; t++) begin
      run_op(10'($urandom_range(0, 10)), 10'($urandom_range(0, 9)), 10'($urandom_range(0, 8)),
             10'($urandom_range(0, 80)), 1'($urandom_range(0, 1)), {$urandom, $urandom},
             0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    bus.start = 1'b0;
    drive_random_inputs();
    test_reset();
    test_overwrite();
    test_clip();
    test_accumulate();
    test_wrap();
    test_control();
    test_zero_cols();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
